fetch_stage: RTL
================

# fetch_stage

Instruction fetch stage sitting directly upstream of the decode stage. It owns the program counter and issues in-order word fetches to instruction memory over a valid/ready request channel. It buffers returned words in a small prefetch FIFO and presents one registered instruction/PC pair per cycle to decode. It handles decode stalls and taken-branch/jump redirects from execute, including discard of in-flight responses to the old path.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- FIFO_DEPTH, 2, prefetch buffer entries; also the cap on requests in flight plus buffered words (power of two, ≥2)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word-aligned fetch address (= fetch_pc)
- imem_rsp_valid  in  1  response valid; responses return in request order, ≥1 cycle after acceptance, never back-pressured
- imem_rsp_data  in  32  fetched instruction word
- redirect_valid  in  1  taken branch/jump from execute
- redirect_pc  in  32  new fetch target
- stall  in  1  decode hazard: hold output register
- instruction  out  instruction_type  instruction to decode
- pc_out  out  32  PC of `instruction`
- instr_valid  out  1  `instruction`/`pc_out` are real, not a bubble
- fetch_misaligned  out  1  registered; set for one cycle when redirect_pc[1:0] != 0

## Operation
- Credit: in_flight (requests accepted, response not yet received, not dropped) + fifo_count < FIFO_DEPTH.
- imem_req_valid = credit && !redirect_valid && !reset. On handshake: fetch_pc += 4, in_flight += 1.
- Response handling: if drop_cnt > 0, the response is discarded and drop_cnt -= 1. Otherwise it is a live word at address rsp_pc (rsp_pc tracks fetch_pc of the oldest in-flight request, +4 per live response).
- Bypass: a live response with the FIFO empty and !stall loads the output register directly. Otherwise it is pushed into the FIFO as {pc, word}.
- Output register, when !stall: loads FIFO head (pop) if non-empty, else bypass word, else bubble (instruction = NOP, instr_valid = 0, pc_out unchanged). When stall: holds all outputs and performs no pop.
- Redirect (overrides stall):
  - fetch_pc ← {redirect_pc[31:2], 2'b00}.
  - FIFO flushed.
  - drop_cnt ← in_flight + drop_cnt.
  - in_flight ← 0; a response arriving in the same cycle counts as already dropped.
  - Output register ← bubble.
  - No request is issued in the redirect cycle; a request may issue the next cycle.
- Misaligned redirect: the low bits are cleared and fetch_misaligned pulses; fetch continues.
- FIFO full: credit guarantees no overflow. A push to a full FIFO is a design error, flagged by an assertion.
- Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.

## Timing
- Reset values:
  - fetch_pc = RESET_PC, rsp_pc = RESET_PC.
  - in_flight = 0, drop_cnt = 0, FIFO empty.
  - instruction = NOP 32'h0000_0013, pc_out = RESET_PC, instr_valid = 0, fetch_misaligned = 0.
  - imem_req_valid = 0 while reset is high.
- First request at the first clock edge after reset deasserts, address RESET_PC.
- Latency: response in cycle N with stall=0 and FIFO empty → instr_valid = 1 from cycle N+1. From the FIFO: head visible → output in the next cycle.
- Single-cycle memory with no stall sustains 1 instruction/cycle once FIFO_DEPTH ≥ 2.
- Redirect in cycle N: bubble at the output in N+1; first new-path request in N+1; earliest new-path instr_valid in N+3 with 1-cycle memory.
- Reset mid-operation clears everything. Stale responses after reset are the memory's responsibility: the memory is reset by the same signal.

## Structure
- Shared package `common`:
  - NOP_INSTR = 32'h0000_0013.
  - instruction_type (existing).
  - fetch_entry_t typedef {pc[31:0], instr[31:0]}.
- Sub-module `fetch_fifo`:
  - parameterized by depth, synchronous push/pop/flush, count output.
  - asynchronous active-high reset.
  - Instantiated once.
- Counters in_flight and drop_cnt are $clog2(FIFO_DEPTH)+1 bits wide.

## Test plan
- Reset release, memory with ready=1 and 1-cycle latency returning addi words: requests to 0x0, 0x4, 0x8 on consecutive cycles; instr_valid high from cycle 2; pc_out 0x0, 0x4, 0x8 in order, one per cycle.
- stall held 3 cycles mid-stream: outputs frozen at pc 0x8. Requests stop after FIFO_DEPTH words are buffered or in flight. After release, pc 0xC and 0x10 appear with no loss or duplicate.
- Memory latency 3 cycles, redirect to 0x100 while 2 requests are in flight: both old responses dropped; the next instr_valid shows pc_out 0x100 with word 0x100's data.
- Redirect and stall asserted in the same cycle: the redirect wins; the output becomes a NOP bubble with instr_valid = 0, and fetch resumes at the target.
- Redirect to 0x102: fetch_misaligned pulses for 1 cycle; imem_req_addr = 0x100.
- Reset asserted asynchronously mid-burst: all outputs return to their reset values without waiting for a clock edge; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/common.sv
// common: constants and types shared by the fetch stage and its prefetch buffer.
package common;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   typedef logic [31:0] instruction_type;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch buffer of {pc, word} entries with flush and occupancy count.
module fetch_fifo
   import common::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push,
   input  logic                    pop,
   input  logic                    flush,
   input  fetch_entry_t            din,
   output fetch_entry_t            dout,
   output logic [$clog2(DEPTH):0]  count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   fetch_entry_t mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic full, do_push, do_pop;
   assign full = count == CW'(DEPTH);
   assign do_pop = pop && count != '0;
   assign do_push = push && (!full || do_pop);
   assign dout = mem[rd_ptr];
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   always_ff @(posedge clk)
      if (do_push && !flush) mem[wr_ptr] <= din;
   // Credit upstream must make this impossible; a hit means the credit logic is broken.
   always_ff @(posedge clk)
      if (!reset && !flush) assert (!(push && full && !pop));
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues in-order word fetches and feeds decode one registered
// instruction per cycle, discarding responses that belong to a redirected path.
module fetch_stage
   import common::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [31:0]     imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [31:0]     redirect_pc,
   input  logic            stall,
   output instruction_type instruction,
   output logic [31:0]     pc_out,
   output logic            instr_valid,
   output logic            fetch_misaligned
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   logic [31:0] fetch_pc, rsp_pc, target;
   logic [CW-1:0] in_flight, drop_cnt, fifo_count;
   logic req_fire, rsp_old, rsp_live, fifo_empty, bypass, push, pop;
   fetch_entry_t head, rsp_entry;
   assign target = {redirect_pc[31:2], 2'b00};
   assign imem_req_valid = ({1'b0, in_flight} + {1'b0, fifo_count} < (CW+1)'(FIFO_DEPTH))
                           && !redirect_valid && !reset;
   assign imem_req_addr = fetch_pc;
   assign req_fire = imem_req_valid && imem_req_ready;
   assign rsp_old = imem_rsp_valid && drop_cnt != '0;
   assign rsp_live = imem_rsp_valid && drop_cnt == '0 && !redirect_valid;
   assign fifo_empty = fifo_count == '0;
   assign bypass = rsp_live && fifo_empty && !stall;
   assign push = rsp_live && !bypass;
   assign pop = !fifo_empty && !stall && !redirect_valid;
   assign rsp_entry = {rsp_pc, imem_rsp_data};
   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .din   (rsp_entry),
      .dout  (head),
      .count (fifo_count)
   );
   // A response arriving during a redirect is already one of the outstanding ones being dropped.
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         fetch_pc <= RESET_PC;
         rsp_pc <= RESET_PC;
         in_flight <= '0;
         drop_cnt <= '0;
      end else if (redirect_valid) begin
         fetch_pc <= target;
         rsp_pc <= target;
         in_flight <= '0;
         drop_cnt <= in_flight + drop_cnt - CW'(imem_rsp_valid);
      end else begin
         if (req_fire) fetch_pc <= fetch_pc + 32'd4;
         if (rsp_live) rsp_pc <= rsp_pc + 32'd4;
         in_flight <= in_flight + CW'(req_fire) - CW'(imem_rsp_valid && drop_cnt == '0);
         drop_cnt <= drop_cnt - CW'(rsp_old);
      end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         instruction <= NOP_INSTR;
         pc_out <= RESET_PC;
         instr_valid <= 1'b0;
         fetch_misaligned <= 1'b0;
      end else begin
         fetch_misaligned <= redirect_valid && redirect_pc[1:0] != 2'b00;
         if (redirect_valid) begin
            instruction <= NOP_INSTR;
            instr_valid <= 1'b0;
         end else if (!stall) begin
            instruction <= pop ? head.instr : bypass ? imem_rsp_data : NOP_INSTR;
            pc_out <= pop ? head.pc : bypass ? rsp_pc : pc_out;
            instr_valid <= pop || bypass;
         end
      end
endmodule
